// File: rtl/hm01b0_sim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hm01b0_sim                                                      |
// | Desc     : HM01B0 8-bit parallel sensor model streaming a stored frame     |
// |            with hsync/vsync strobes; option HM01B0_SIM_TEST_PATTERN_EN     |
// |            replaces the image with a (row+col) ramp.                        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module hm01b0_sim #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int H_BLANK = 20,
  parameter int V_BLANK = 20
) (
  input  logic       mclk,
  input  logic       reset,
  output logic       clock,
  output logic [7:0] pixdata,
  output logic       hsync,
  output logic       vsync
);

  localparam int C_LINE_LEN    = WIDTH + H_BLANK;
  localparam int C_FRAME_LINES = HEIGHT + V_BLANK;
  localparam int C_COL_W       = $clog2(C_LINE_LEN + 1);
  localparam int C_ROW_W       = $clog2(C_FRAME_LINES + 1);
  localparam int C_PIX_W       = $clog2(WIDTH * HEIGHT + 1);
  localparam int C_ADDR_W      = (C_PIX_W > 17) ? C_PIX_W : 17;

  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(C_LINE_LEN - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(C_FRAME_LINES - 1);
  localparam logic [C_COL_W-1:0] C_WIDTH    = C_COL_W'(WIDTH);
  localparam logic [C_ROW_W-1:0] C_HEIGHT   = C_ROW_W'(HEIGHT);

  // Frame store, loaded from outside by hierarchical name.
  logic [7:0] hm01b0_image [0:WIDTH*HEIGHT-1];

  logic [C_COL_W-1:0] r_col;
  logic [C_ROW_W-1:0] r_row;
  logic [7:0]         r_pixdata;
  logic               r_hsync;
  logic               r_vsync;

  logic               w_vactive;
  logic               w_hactive;
  logic [7:0]         w_pix;

  assign w_vactive = (r_row < C_HEIGHT);
  assign w_hactive = w_vactive && (r_col < C_WIDTH);

`ifdef HM01B0_SIM_TEST_PATTERN_EN
  logic [C_ADDR_W-1:0] w_sum;
  assign w_sum = C_ADDR_W'(r_row) + C_ADDR_W'(r_col);
  assign w_pix = w_hactive ? w_sum[7:0] : 8'h00;
`else
  logic [C_ADDR_W-1:0] w_addr;
  assign w_addr = C_ADDR_W'(r_row) * C_ADDR_W'(WIDTH) + C_ADDR_W'(r_col);
  // Guard the read so blank-region addresses never index past the array.
  assign w_pix  = w_hactive ? hm01b0_image[w_addr] : 8'h00;
`endif

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_pixdata <= 8'h00;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
    end else begin
      r_vsync   <= w_vactive;
      r_hsync   <= w_hactive;
      r_pixdata <= w_pix;
      if (r_col == C_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign clock   = ~mclk;
  assign pixdata = r_pixdata;
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_hm01b0_sim.sv
`default_nettype none
// Scoreboard bench for hm01b0_sim: reference model queues expected outputs per edge;
// sync-edge bookkeeping checks line spacing, frame period and vertical blank length.
module tb_hm01b0_sim;

  localparam int W     = 250;
  localparam int H     = 10;
  localparam int HB    = 5;
  localparam int VB    = 2;
  localparam int LINE  = W + HB;
  localparam int FRAME = LINE * (H + VB);

  logic       mclk;
  logic       reset;
  logic       clock;
  logic [7:0] pixdata;
  logic       hsync;
  logic       vsync;

  hm01b0_sim #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .mclk    (mclk),
    .reset   (reset),
    .clock   (clock),
    .pixdata (pixdata),
    .hsync   (hsync),
    .vsync   (vsync)
  );

  typedef struct packed {
    logic       r;
    logic       h;
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] img [0:W*H-1];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_row   = 0;
  int         m_col   = 0;
  int         cyc     = 0;

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int row, input int col);
`ifdef HM01B0_SIM_TEST_PATTERN_EN
    ref_pix = 8'((row + col) % 256);
`else
    ref_pix = img[row*W + col];
`endif
  endfunction

  // Reference model: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge mclk);
      e.r = reset;
      if (reset) begin
        e.h = 1'b0; e.v = 1'b0; e.d = 8'h00;
        m_row = 0; m_col = 0;
      end else begin
        e.v = (m_row < H);
        e.h = e.v && (m_col < W);
        e.d = e.h ? ref_pix(m_row, m_col) : 8'h00;
        if (m_col == LINE - 1) begin
          m_col = 0;
          m_row = (m_row == H + VB - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
      q.push_back(e);
    end
  end

  // Checker: pops one entry per cycle and tracks sync-edge timing.
  initial begin
    exp_t e;
    logic prev_h = 1'b0, prev_v = 1'b0, have_vrise = 1'b0;
    int   hcnt = 0, last_h = 0, last_v = 0, vlow = 0;
    forever begin
      @(negedge mclk);
      cyc++;
      check_val("clock_is_not_mclk", {31'd0, clock}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_val("hsync", {31'd0, hsync}, {31'd0, e.h});
        check_val("vsync", {31'd0, vsync}, {31'd0, e.v});
        check_val("pixdata", {24'd0, pixdata}, {24'd0, e.d});
        if (e.r) begin
          prev_h = 1'b0; prev_v = 1'b0; have_vrise = 1'b0;
          hcnt = 0; vlow = 0;
        end else begin
          if (vsync && !prev_v) begin
            if (have_vrise) begin
              check_val("frame_period", cyc - last_v, FRAME);
              check_val("hsync_rises_per_frame", hcnt, H);
              check_val("vblank_len", vlow, VB * LINE);
            end
            have_vrise = 1'b1; last_v = cyc; hcnt = 0; vlow = 0;
          end
          if (hsync && !prev_h) begin
            if (hcnt > 0) check_val("line_spacing", cyc - last_h, LINE);
            hcnt++;
            last_h = cyc;
          end
          if (!vsync) vlow++;
          prev_h = hsync;
          prev_v = vsync;
        end
      end
    end
  end

  initial begin
    bit hit;
    reset = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      img[i] = 8'($urandom_range(0, 255));
      dut.hm01b0_image[i] = img[i];
    end
    repeat (4) @(negedge mclk);
    reset = 1'b0;
    repeat (2*FRAME + LINE) @(negedge mclk);

    // Abort mid-frame with a single-cycle reset.
    hit = 1'b0;
    for (int k = 0; k < FRAME && !hit; k++) begin
      @(negedge mclk);
      if (m_row == 5 && m_col == 50) hit = 1'b1;
    end
    check_val("reached_row5_col50", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    repeat (FRAME + 2*LINE) @(negedge mclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
